// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, FSM states and
// the helper that decides which operations take the multi-cycle datapath.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;
  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Division by zero is resolved in a single cycle, so it never enters BUSY.
  function automatic logic is_iterative(input logic [4:0] op, input logic b_zero);
    return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
  endfunction

endpackage

// File: rtl/multdiv_iter.sv
// Iterative signed multiply (shift-add) and restoring divide on operand
// magnitudes; one step per cycle for WIDTH cycles, sign applied on the last step.
module multdiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             overflow_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic             busy_q, div_q, neg_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] acc_q, sr_q, opnd_q;
  logic [WIDTH-1:0] acc_d, sr_d;
  logic [WIDTH-1:0] mag_a, mag_b, rem_sh, quo_s;
  logic [WIDTH:0]   sum, diff;
  logic [2*WIDTH-1:0] prod_s;

  // The magnitude of the most negative value is representable as unsigned.
  assign mag_a = a_i[WIDTH-1] ? -a_i : a_i;
  assign mag_b = b_i[WIDTH-1] ? -b_i : b_i;

  // acc_q holds the product high half / partial remainder, sr_q the
  // multiplier / dividend being shifted out and quotient bits shifted in.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    acc_d  = acc_q;
    sr_d   = sr_q;
    sum    = {1'b0, acc_q} + (sr_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh = {acc_q[WIDTH-2:0], sr_q[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {1'b0, opnd_q};
    if (div_q) begin
      if (!diff[WIDTH]) begin
        acc_d = diff[WIDTH-1:0];
        sr_d  = {sr_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_sh;
        sr_d  = {sr_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = sum[WIDTH:1];
      sr_d  = {sum[0], sr_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_s     = neg_q ? -{acc_d, sr_d} : {acc_d, sr_d};
    quo_s      = neg_q ? -sr_d : sr_d;
    result_o   = prod_s[WIDTH-1:0];
    overflow_o = prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}};
    if (div_q) begin
      result_o   = quo_s;
      // Only MIN / -1 yields a positive quotient of magnitude 2^(WIDTH-1).
      overflow_o = !neg_q && sr_d[WIDTH-1];
    end
  end

  assign done_o = busy_q && (cnt_q == LAST);

  // NOTE: datapath registers are reset as well, so an aborted operation leaves no stale state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      sr_q   <= '0;
      opnd_q <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      div_q  <= (op_i == OP_DIV);
      neg_q  <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
      cnt_q  <= '0;
      acc_q  <= '0;
      sr_q   <= mag_a;
      opnd_q <= mag_b;
    end else if (busy_q) begin
      acc_q <= acc_d;
      sr_q  <= sr_d;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes: single-cycle ops complete in one
// cycle, MUL/DIV run WIDTH cycles in multdiv_iter; results held until consumed.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [4:0]       ctrl_ALUopcode,
  input  logic [SHW-1:0]   ctrl_shiftamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             isNotEqual,
  output logic             isLessThan,
  output logic             overflow,
  output logic             exception
);

  state_e           state_q;
  logic             out_valid_q, ne_q, lt_q, ovf_q, exc_q;
  logic [WIDTH-1:0] result_q;

  logic             accept, b_zero, start_iter;
  logic [WIDTH-1:0] add_r, sub_r, res_d;
  logic             ovf_d, exc_d;
  logic             md_done, md_ovf;
  logic [WIDTH-1:0] md_result;

  assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign b_zero     = (data_operandB == '0);
  assign start_iter = accept && is_iterative(ctrl_ALUopcode, b_zero);

  always_comb begin
    add_r = data_operandA + data_operandB;
    sub_r = data_operandA - data_operandB;
    res_d = '0;
    ovf_d = 1'b0;
    exc_d = 1'b0;
    case (ctrl_ALUopcode)
      OP_ADD: begin
        res_d = add_r;
        ovf_d = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
                (add_r[WIDTH-1] != data_operandA[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = sub_r;
        ovf_d = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) &&
                (sub_r[WIDTH-1] != data_operandA[WIDTH-1]);
      end
      OP_AND: res_d = data_operandA & data_operandB;
      OP_OR:  res_d = data_operandA | data_operandB;
      OP_SLL: res_d = data_operandA << ctrl_shiftamt;
      OP_SRA: res_d = $signed(data_operandA) >>> ctrl_shiftamt;
      OP_MUL: exc_d = 1'b0;
      OP_DIV: exc_d = b_zero;
      default: exc_d = 1'b1;
    endcase
  end

  multdiv_iter #(.WIDTH(WIDTH)) u_multdiv (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .start_i    (start_iter),
    .op_i       (ctrl_ALUopcode),
    .a_i        (data_operandA),
    .b_i        (data_operandB),
    .done_o     (md_done),
    .result_o   (md_result),
    .overflow_o (md_ovf)
  );

  // An accepted request always wins: from IDLE, or from DONE on the same
  // edge the current result is consumed, giving back-to-back throughput.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ne_q        <= 1'b0;
      lt_q        <= 1'b0;
      ovf_q       <= 1'b0;
      exc_q       <= 1'b0;
    end else if (accept) begin
      ne_q <= (data_operandA != data_operandB);
      lt_q <= ($signed(data_operandA) < $signed(data_operandB));
      if (start_iter) begin
        state_q     <= ST_BUSY;
        out_valid_q <= 1'b0;
      end else begin
        state_q     <= ST_DONE;
        out_valid_q <= 1'b1;
        result_q    <= res_d;
        ovf_q       <= ovf_d;
        exc_q       <= exc_d;
      end
    end else begin
      case (state_q)
        ST_BUSY: begin
          if (md_done) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= md_result;
            ovf_q       <= md_ovf;
            exc_q       <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign data_result = result_q;
  assign isNotEqual  = ne_q;
  assign isLessThan  = lt_q;
  assign overflow    = ovf_q;
  assign exception   = exc_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: requests push model results into a queue, a
// monitor pops and compares on every presented output.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W   = 32;
  localparam int SHW = 5;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   data_operandA = '0;
  logic [W-1:0]   data_operandB = '0;
  logic [4:0]     ctrl_ALUopcode = '0;
  logic [SHW-1:0] ctrl_shiftamt = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   data_result;
  logic           isNotEqual, isLessThan, overflow, exception;

  typedef struct {
    logic [W-1:0] res;
    logic         ne, lt, ovf, exc;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   bp_mode = 0;
  bit   first_seen = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_ALUopcode (ctrl_ALUopcode),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .data_result    (data_result),
    .isNotEqual     (isNotEqual),
    .isLessThan     (isLessThan),
    .overflow       (overflow),
    .exception      (exception)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Consumer back-pressure: 0 always ready, 1 random, 2 stalled.
  always @(posedge clock) begin
    #2;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: plain 64-bit signed arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [4:0] op, input logic [SHW-1:0] sh);
    exp_t   e;
    longint sa, sb, full;
    sa = $signed(a);
    sb = $signed(b);
    e.ne = (a != b);
    e.lt = (sa < sb);
    e.res = '0;
    e.ovf = 1'b0;
    e.exc = 1'b0;
    e.lat = 1;
    e.acc_cyc = 0;
    case (op)
      OP_ADD: begin full = sa + sb; e.res = full[W-1:0]; e.ovf = (full > MAXV) || (full < MINV); end
      OP_SUB: begin full = sa - sb; e.res = full[W-1:0]; e.ovf = (full > MAXV) || (full < MINV); end
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_SLL: e.res = a << sh;
      OP_SRA: begin full = sa >>> sh; e.res = full[W-1:0]; end
      OP_MUL: begin
        full = sa * sb;
        e.res = full[W-1:0];
        e.ovf = (full > MAXV) || (full < MINV);
        e.lat = W + 1;
      end
      OP_DIV: begin
        if (b == '0) begin
          e.exc = 1'b1;
        end else begin
          full = sa / sb;
          e.res = full[W-1:0];
          e.ovf = (full > MAXV) || (full < MINV);
          e.lat = W + 1;
        end
      end
      default: e.exc = 1'b1;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] op, input logic [SHW-1:0] sh);
    exp_t e;
    int   waitc;
    @(negedge clock);
    data_operandA  = a;
    data_operandB  = b;
    ctrl_ALUopcode = op;
    ctrl_shiftamt  = sh;
    in_valid       = 1'b1;
    #1;
    waitc = 0;
    while (!in_ready && waitc < 200) begin
      @(negedge clock);
      #1;
      waitc++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    e = model(a, b, op, sh);
    e.acc_cyc = cyc;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("drain_queue_empty", sb_q.size(), 0);
    @(negedge clock);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [4:0] rnd_op();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return 5'(r);
    return 5'($urandom_range(8, 31));
  endfunction

  // Monitor: compares every presented output against the queue head, checks
  // latency on its first cycle, pops on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && out_valid) begin
        if (sb_q.size() == 0) begin
          check("out_valid_unexpected", out_valid, 0);
        end else begin
          e = sb_q[0];
          if (!first_seen) begin
            check("latency", cyc - e.acc_cyc, e.lat);
            first_seen = 1'b1;
          end
          check("data_result", data_result, e.res);
          check("isNotEqual", isNotEqual, e.ne);
          check("isLessThan", isLessThan, e.lt);
          check("overflow", overflow, e.ovf);
          check("exception", exception, e.exc);
          if (out_ready) begin
            void'(sb_q.pop_front());
            first_seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_data_result", data_result, 0);
    check("rst_flags", {isNotEqual, isLessThan, overflow, exception}, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Directed cases including the called-out boundaries.
    issue(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 0);
    issue(32'hFFFF_FFF9, 32'h0000_0006, OP_MUL, 0);
    issue(32'h0001_0000, 32'h0001_0000, OP_MUL, 0);
    issue(32'hFFFF_FFF9, 32'h0000_0002, OP_DIV, 0);
    issue(32'h0000_0005, 32'h0000_0000, OP_DIV, 0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, OP_DIV, 0);
    issue(32'h0000_0003, 32'h0000_0005, OP_SUB, 0);
    issue(32'h0000_0010, 32'h0000_0020, OP_ADD, 0);
    issue(32'h1234_5678, 32'h0000_0000, 5'b01000, 0);
    wait_drain();

    // Held result under back-pressure; requests meanwhile must be ignored.
    bp_mode = 2;
    @(posedge clock);
    #3;
    issue(32'h8000_0000, 32'h0000_0000, OP_SRA, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      data_operandA  = 32'h0000_0001;
      data_operandB  = 32'h0000_0001;
      ctrl_ALUopcode = OP_ADD;
      in_valid       = 1'b1;
      #1;
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
    end
    @(negedge clock);
    in_valid = 1'b0;
    bp_mode = 0;
    wait_drain();

    // Reset in the middle of a multiply aborts it without any output.
    issue(32'h0000_0007, 32'h0000_0009, OP_MUL, 0);
    repeat (9) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_data_result", data_result, 0);
    sb_q.delete();
    first_seen = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("post_reset_in_ready", in_ready, 1);
    issue(32'h0000_0002, 32'h0000_0002, OP_ADD, 0);
    wait_drain();

    // Randomized traffic with random consumer back-pressure.
    bp_mode = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
      issue(rnd_operand(), rnd_operand(), rnd_op(), 5'($urandom_range(0, 31)));
    end
    bp_mode = 0;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
